// File: rtl/spi_burst_memory.sv
// SPI-slave (mode 0) memory with ADDR_W address bits, R/W bit, then DATA_W-bit words.
// Define SPI_BURST_AUTOINC_EN for unlimited auto-incrementing bursts; otherwise one word per frame.
module spi_burst_memory #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
    output logic       miso_pin,
    output logic       miso_oe,
    output logic       busy,
    output logic [2:0] leds
);
    // state    | meaning
    // IDLE  0  | waiting for cs falling
    // ADDR  1  | shifting in address and R/W bit
    // RLOAD 2  | one clk loading mem[addr] into the shift register
    // READ  3  | shifting data out on MISO
    // WRITE 4  | shifting data in from MOSI
    // HOLD  5  | ignoring sclk until cs rises
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_RLOAD = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;
    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    logic [2:0]        r_sync [SYNC_STAGES];
    logic [2:0]        w_sync;
    logic              r_sclk_prev, r_cs_prev;
    logic              r_sclk_rise, r_sclk_fall, r_cs_fall, r_cs_high, r_mosi;
    state_t            r_state;
    logic              r_oe, r_miso, r_wr_pend;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bitcnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Synchroniser is left unreset so a reset mid-frame cannot fabricate a cs falling edge.
    always_ff @(posedge clk) begin
        r_sync[0] <= {sclk_pin, cs_pin, mosi_pin};
        for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b0;
            r_sclk_rise <= 1'b0;
            r_sclk_fall <= 1'b0;
            r_cs_fall   <= 1'b0;
            r_cs_high   <= 1'b0;
            r_mosi      <= 1'b0;
        end else begin
            r_sclk_prev <= w_sync[2];
            r_cs_prev   <= w_sync[1];
            r_sclk_rise <= w_sync[2] & ~r_sclk_prev;
            r_sclk_fall <= ~w_sync[2] & r_sclk_prev;
            r_cs_fall   <= ~w_sync[1] & r_cs_prev;
            r_cs_high   <= w_sync[1];
            r_mosi      <= w_sync[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_oe      <= 1'b0;
            r_miso    <= 1'b0;
            r_wr_pend <= 1'b0;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_addr    <= '0;
        end else begin
            r_wr_pend <= 1'b0;
`ifdef SPI_BURST_AUTOINC_EN
            if (r_wr_pend) r_addr <= r_addr + ADDR_W'(1);
`endif
            // A completed word still commits even if cs rises right behind it.
            if (r_cs_high) begin
                if (r_state != ST_IDLE) begin
                    r_state  <= ST_IDLE;
                    r_oe     <= 1'b0;
                    r_bitcnt <= '0;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_cs_fall) begin
                            r_state  <= ST_ADDR;
                            r_bitcnt <= '0;
                        end
                    end
                    ST_ADDR: begin
                        if (r_sclk_rise) begin
                            if (r_bitcnt == CNT_W'(ADDR_W)) begin
                                r_bitcnt <= '0;
                                if (r_mosi) begin
                                    r_state <= ST_RLOAD;
                                    r_oe    <= 1'b1;
                                end else begin
                                    r_state <= ST_WRITE;
                                end
                            end else begin
                                r_addr   <= {r_addr[ADDR_W-2:0], r_mosi};
                                r_bitcnt <= r_bitcnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_RLOAD: begin
                        r_shift <= r_mem[r_addr];
                        r_state <= ST_READ;
                    end
                    ST_READ: begin
                        if (r_sclk_fall) begin
                            r_miso  <= r_shift[DATA_W-1];
                            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                        end else if (r_sclk_rise) begin
                            if (r_bitcnt == CNT_W'(DATA_W - 1)) begin
                                r_bitcnt <= '0;
`ifdef SPI_BURST_AUTOINC_EN
                                r_addr  <= r_addr + ADDR_W'(1);
                                r_state <= ST_RLOAD;
`else
                                r_state <= ST_HOLD;
                                r_oe    <= 1'b0;
`endif
                            end else begin
                                r_bitcnt <= r_bitcnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (r_sclk_rise) begin
                            r_shift <= {r_shift[DATA_W-2:0], r_mosi};
                            if (r_bitcnt == CNT_W'(DATA_W - 1)) begin
                                r_bitcnt  <= '0;
                                r_wr_pend <= 1'b1;
`ifndef SPI_BURST_AUTOINC_EN
                                r_state   <= ST_HOLD;
`endif
                            end else begin
                                r_bitcnt <= r_bitcnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_HOLD: ;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_wr_pend && !reset) r_mem[r_addr] <= r_shift;
    end

    assign miso_oe  = r_oe;
    assign miso_pin = r_oe ? r_miso : 1'bz;
    assign busy     = (r_state != ST_IDLE);
    assign leds     = r_state;

endmodule

// File: tb/tb_spi_burst_memory.sv
// Bench for spi_burst_memory: bit-banged SPI master against a word-level memory model.
// Follows SPI_BURST_AUTOINC_EN the same way the design does.
module tb_spi_burst_memory;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int SYNC   = 2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int HALF   = 8;
`ifdef SPI_BURST_AUTOINC_EN
    localparam int BURST_MAX = 1 << 20;
`else
    localparam int BURST_MAX = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk_pin = 1'b0;
    logic       cs_pin = 1'b1;
    logic       mosi_pin = 1'b0;
    logic       miso_pin;
    logic       miso_oe;
    logic       busy;
    logic [2:0] leds;

    always #5 clk = ~clk;

    spi_burst_memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .sclk_pin(sclk_pin), .cs_pin(cs_pin), .mosi_pin(mosi_pin),
        .miso_pin(miso_pin), .miso_oe(miso_oe), .busy(busy), .leds(leds)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  ref_mem   [DEPTH];
    bit          ref_known [DEPTH];
    logic        oe_all, oe_any;
    logic [7:0]  wbuf [4];
    logic [7:0]  rbuf [4];
    logic [6:0]  rnd_addr [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer_bit(input logic b, output logic r);
        mosi_pin = b;
        repeat (HALF) @(negedge clk);
        r = miso_pin;
        oe_all = oe_all & miso_oe;
        oe_any = oe_any | miso_oe;
        sclk_pin = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk_pin = 1'b0;
    endtask

    task automatic xfer_word(input logic [7:0] w, output logic [7:0] r);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(w[i], b);
            r[i] = b;
        end
    endtask

    task automatic frame_start(input logic [6:0] a, input logic rd);
        logic b;
        @(negedge clk);
        cs_pin = 1'b0;
        repeat (HALF) @(negedge clk);
        chk("busy_in_frame", busy, 1);
        for (int i = 6; i >= 0; i--) xfer_bit(a[i], b);
        xfer_bit(rd, b);
    endtask

    task automatic frame_end();
        cs_pin = 1'b1;
        repeat (12) @(negedge clk);
        chk("oe_after_frame", miso_oe, 0);
    endtask

    // Model: only completed words commit, to consecutive addresses (mod depth) up to BURST_MAX.
    task automatic do_write(input logic [6:0] a, input int n);
        logic [7:0] dummy;
        frame_start(a, 1'b0);
        oe_any = 1'b0;
        for (int i = 0; i < n; i++) xfer_word(wbuf[i], dummy);
        chk("write_oe", oe_any, 0);
        frame_end();
        for (int i = 0; i < n && i < BURST_MAX; i++) begin
            ref_mem[(int'(a) + i) % DEPTH]   = wbuf[i];
            ref_known[(int'(a) + i) % DEPTH] = 1'b1;
        end
    endtask

    task automatic do_read(input logic [6:0] a, input int n, input string tag);
        int ea;
        frame_start(a, 1'b1);
        for (int i = 0; i < n; i++) begin
            oe_all = 1'b1;
            oe_any = 1'b0;
            xfer_word(8'h00, rbuf[i]);
            ea = (int'(a) + i) % DEPTH;
            if (i < BURST_MAX) begin
                chk({tag, "_oe"}, oe_all, 1);
                if (ref_known[ea]) chk({tag, "_data"}, rbuf[i], ref_mem[ea]);
            end else begin
                chk({tag, "_oe_off"}, oe_any, 0);
            end
        end
        frame_end();
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [6:0] a;
        logic       b;
        logic [7:0] dummy;

        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_oe", miso_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_leds", leds, 0);

        for (int i = 0; i < 4; i++) begin
            sclk_pin = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk_pin = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        chk("cs_high_sclk_leds", leds, 0);
        chk("cs_high_sclk_busy", busy, 0);

        wbuf[0] = 8'hA5;
        do_write(7'h05, 1);
        do_read(7'h05, 1, "rd05");
        chk("rd05_value", rbuf[0], 8'hA5);

        for (int k = 0; k < 6; k++) begin
            a = 7'($urandom_range(0, DEPTH - 1));
            wbuf[0] = 8'($urandom);
            do_write(a, 1);
            rnd_addr.push_back(a);
            do_read(a, 1, "rnd");
        end

        // Abort: cs rises after 4 data bits; the partial word must not land.
        wbuf[0] = 8'h3C;
        do_write(7'h10, 1);
        frame_start(7'h10, 1'b0);
        for (int i = 0; i < 4; i++) xfer_bit(1'b1, b);
        cs_pin = 1'b1;
        repeat (SYNC + 2) @(posedge clk);
        #1;
        chk("abort_leds", leds, 0);
        chk("abort_busy", busy, 0);
        repeat (12) @(negedge clk);
        do_read(7'h10, 1, "abort_rd");
        chk("abort_value", rbuf[0], 8'h3C);

        // Reset mid-read, remaining sclk ignored until cs cycles.
        frame_start(7'h05, 1'b1);
        for (int i = 0; i < 3; i++) xfer_bit(1'b0, b);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_oe", miso_oe, 0);
        chk("midrst_leds", leds, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) xfer_bit(1'b1, b);
        chk("midrst_ignored", busy, 0);
        cs_pin = 1'b1;
        repeat (12) @(negedge clk);
        do_read(7'h05, 1, "post_rst");

`ifdef SPI_BURST_AUTOINC_EN
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        do_write(7'h7F, 2);
        do_read(7'h7F, 2, "burst_rd");
        chk("burst_w0", rbuf[0], 8'h11);
        chk("burst_w1", rbuf[1], 8'h22);
        do_read(7'h00, 1, "wrap_rd");
        chk("wrap_value", rbuf[0], 8'h22);
`else
        wbuf[0] = 8'h5A;
        do_write(7'h21, 1);
        frame_start(7'h20, 1'b0);
        xfer_word(8'h77, dummy);
        chk("single_hold_leds", leds, 5);
        xfer_word(8'h88, dummy);
        frame_end();
        ref_mem[7'h20]   = 8'h77;
        ref_known[7'h20] = 1'b1;
        do_read(7'h20, 2, "single_rd");
        chk("single_w20", rbuf[0], 8'h77);
        do_read(7'h21, 1, "single_next");
        chk("single_w21", rbuf[0], 8'h5A);
`endif

        foreach (rnd_addr[i]) do_read(rnd_addr[i], 1, "reread");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_burst_memory.md
# spi_burst_memory

SPI-slave-accessible on-chip memory with parametrised address width, data width and depth, plus multi-word burst transfers with automatic address increment. Sits between the board-level SPI pins and the FPGA fabric. Provides the same single-word read/write service as the current SPI memory, generalised beyond one 8-bit frame per transaction. Input synchronisation, edge detection, shift register, address counter, storage array and MISO tristate control are all internal to this block.

## Interface
Parameters:
- ADDR_W, 7, address bits sent per transaction; memory depth is 2**ADDR_W words
- DATA_W, 8, bits per memory word and per SPI data word
- SYNC_STAGES, 2, flip-flop synchroniser depth on sclk_pin, cs_pin and mosi_pin

Ports:
- clk  in  1  FPGA clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- sclk_pin  in  1  SPI clock, asynchronous to clk, idle low (mode 0)
- cs_pin  in  1  SPI chip select, active low
- mosi_pin  in  1  master out, slave in; MSB first
- miso_pin  out  1  master in, slave out; high-impedance whenever miso_oe = 0
- miso_oe  out  1  MISO drive enable
- busy  out  1  high while a transaction is in progress (state ≠ IDLE)
- leds  out  3  current FSM state encoding, for debug

## Operation
- Frame layout: ADDR_W address bits, MSB first, then one R/W bit (1 = read, 0 = write), then zero or more DATA_W-bit data words, MSB first.
- MOSI is sampled on the sclk rising edge. MISO is updated on the sclk falling edge.
- FSM states (leds value):
  - IDLE (0): waiting for cs low.
  - ADDR (1): shifting in address and R/W bits.
  - RLOAD (2): one clk cycle spent reading memory into the shift register.
  - READ (3): shifting data out on MISO.
  - WRITE (4): shifting data in from MOSI.
  - HOLD (5): ignoring sclk until cs goes high.
- Transitions:
  - IDLE→ADDR on synchronised cs falling.
  - ADDR→RLOAD or ADDR→WRITE on the rising edge that captures the R/W bit.
  - RLOAD→READ after one clk.
  - In READ, the rising edge completing a word increments the address and re-enters RLOAD.
  - In WRITE, the rising edge completing a word commits the word to mem[addr] on the next clk, then increments the address.
- Address increment wraps modulo 2**ADDR_W (max → 0).
- miso_oe is 1 only in RLOAD/READ. miso_pin shows the MSB of the loaded word from the first sclk falling edge after RLOAD.
- Synchronised cs going high in any state → IDLE on the next clk, miso_oe = 0. A partially shifted write word is discarded and never written. Completed words remain written.
- cs high and an sclk edge in the same clk cycle: cs wins and the edge is ignored.
- Memory contents are not cleared by reset.
- Reset (may arrive mid-transaction):
  - state = IDLE, miso_oe = 0, busy = 0, leds = 0.
  - Shift register, bit counter and address are cleared to 0.
  - The rest of the transaction is ignored until cs goes high and falls again.

## Timing
- Pin-to-action latency: SYNC_STAGES + 1 clk from a pin edge to the corresponding internal edge strobe.
- Each sclk high phase and low phase must last at least SYNC_STAGES + 3 clk cycles. cs setup to the first sclk rise must be at least the same.
- Read access latency: 1 clk in RLOAD, fully hidden within one sclk half-period.
- Write commit: mem[addr] is updated 1 clk after the strobe of the last bit of the word.
- busy asserts 1 clk after the synchronised cs falls. It deasserts 1 clk after the synchronised cs rises.

## Configuration
- SPI_BURST_AUTOINC_EN defined:
  - Bursts are unlimited in length.
  - The address increments and wraps after every data word, as described above.
- Not defined:
  - Exactly one data word per transaction. After the first word completes, the FSM enters HOLD and miso_oe = 0.
  - Subsequent sclk edges are ignored and no further writes occur.
  - The address incrementer is not built.

## Test plan
- Reset with cs high → miso_oe = 0, busy = 0, leds = 0. Sclk toggling with cs high does not change state.
- Write addr 0x05 data 0xA5, then read addr 0x05 → MISO returns 0xA5 MSB first; miso_oe high only during the read frame.
- With AUTOINC_EN: burst write at 0x7F of 0x11, 0x22 → mem[0x7F] = 0x11 and mem[0x00] = 0x22 (wrap). A burst read from 0x7F returns 0x11, 0x22.
- Write frame to 0x10, cs raised after 4 data bits → mem[0x10] unchanged, FSM in IDLE within SYNC_STAGES + 2 clk.
- Reset asserted mid-read → miso_oe = 0 on the next clk. A fresh transaction after cs cycles completes normally.
- Without AUTOINC_EN: a 2-word write to 0x20 → only mem[0x20] is written, mem[0x21] is unchanged, and leds = 5 after the first word.
